// File: rtl/fft_host_pkg.sv
// rtl/fft_host_pkg.sv - shared types and constants for the FFT frame host
//
// Purpose: FSM state encoding and protocol constants for the host side of
// the 8-point FFT magnitude core's slot-sequenced byte protocol.
// Ports: none (package).
package fft_host_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SYNC,
    ST_RUN,
    ST_CAPT
  } state_t;

  localparam int N_SAMP    = 8;
  localparam int LAST_SLOT = 11;
  localparam int CAPT_SLOT = 12;
  localparam int CODE_W    = 2;
  localparam int N_BINS    = 8;

endpackage

// File: rtl/fft_bin_peak.sv
// rtl/fft_bin_peak.sv - combinational peak finder over packed 2-bit bin codes
//
// Purpose: find the bin with the largest 2-bit unsigned code; ties resolve
// to the lowest index. Also flags whether any code is nonzero.
// Ports:
//   flags - in,  16: packed codes, bin k at [2k+1:2k]
//   peak  - out, 3 : index of the largest code
//   any   - out, 1 : high if any code is nonzero
module fft_bin_peak
  import fft_host_pkg::*;
(
  input  logic [15:0] flags,
  output logic [2:0]  peak,
  output logic        any
);

  logic [CODE_W-1:0] best_code;

  // Strict greater-than keeps the earliest bin on ties.
  always_comb begin
    peak      = '0;
    best_code = flags[CODE_W-1:0];
    for (int k = 1; k < N_BINS; k++) begin
      if (flags[k*CODE_W +: CODE_W] > best_code) begin
        best_code = flags[k*CODE_W +: CODE_W];
        peak      = 3'(k);
      end
    end
  end

  assign any = |flags;

endmodule

// File: rtl/fft_frame_host.sv
// rtl/fft_frame_host.sv - host-side frame driver for the 8-point FFT magnitude core
//
// Purpose: buffer N_SAMP samples, reset-align the core's slot counter, drive
// one sample per slot, capture the packed bin-flag word on slot CAPT_SLOT and
// present it with a peak-bin summary.
// Optional feature: FFT_HOST_OVERRUN_EN - never stall for the result register;
// a capture over an unconsumed result sets the sticky overrun flag.
// Ports:
//   clk, rst_n                - clock, synchronous active-low reset
//   s_valid/s_ready/s_data    - sample input stream
//   dut_rst_n/dut_ena/dut_data- core reset, enable and per-slot sample
//   dut_result                - core packed flags {uio_out, uo_out}
//   r_valid/r_ready           - result handshake
//   r_bins/r_peak/r_any       - captured flags and peak summary
//   overrun                   - sticky overrun (0 unless FFT_HOST_OVERRUN_EN)
module fft_frame_host
  import fft_host_pkg::*;
#(
  parameter int N_SAMP    = fft_host_pkg::N_SAMP,
  parameter int SAMP_W    = 8,
  parameter int CAPT_SLOT = fft_host_pkg::CAPT_SLOT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [SAMP_W-1:0] s_data,
  output logic              dut_rst_n,
  output logic              dut_ena,
  output logic [SAMP_W-1:0] dut_data,
  input  logic [15:0]       dut_result,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [15:0]       r_bins,
  output logic [2:0]        r_peak,
  output logic              r_any,
  output logic              overrun
);

  localparam int CNT_W  = $clog2(N_SAMP + 1);
  localparam int IDX_W  = $clog2(N_SAMP);
  localparam int SLOT_W = $clog2(CAPT_SLOT + 1);
  localparam int LAST   = CAPT_SLOT - 1;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic [SLOT_W-1:0] slot;
  logic [SAMP_W-1:0] samp_buf [N_SAMP];
  logic              accept;
  logic              full;
  logic              hold;
  logic [2:0]        peak_idx;
  logic              peak_any;

  fft_bin_peak u_peak (
    .flags (dut_result),
    .peak  (peak_idx),
    .any   (peak_any)
  );

  assign s_ready = rst_n && (state == ST_FILL) && (count < CNT_W'(N_SAMP));
  assign accept  = s_valid && s_ready;

  // Buffer counts as full in the same cycle the last sample is accepted,
  // so SYNC follows the final accept by exactly one cycle.
  assign full = (count == CNT_W'(N_SAMP)) ||
                (accept && (count == CNT_W'(N_SAMP - 1)));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    dut_rst_n  = rst_n;
    dut_ena    = 1'b0;
    dut_data   = '0;
    case (state)
      ST_FILL: if (full && !hold) state_next = ST_SYNC;
      ST_SYNC: begin
        // Enable must stay low: the core's enable branch beats its reset.
        dut_rst_n  = 1'b0;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        dut_ena = 1'b1;
        if (slot < SLOT_W'(N_SAMP)) dut_data = samp_buf[slot[IDX_W-1:0]];
        if (slot == SLOT_W'(LAST)) state_next = ST_CAPT;
      end
      ST_CAPT: state_next = ST_FILL;
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) samp_buf[count[IDX_W-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      slot    <= '0;
      r_valid <= 1'b0;
      r_bins  <= '0;
      r_peak  <= '0;
      r_any   <= 1'b0;
    end else begin
      if (accept) count <= count + CNT_W'(1);
      if (state == ST_SYNC)     slot <= '0;
      else if (state == ST_RUN) slot <= slot + SLOT_W'(1);
      // Capture wins over consume, so a same-cycle r_ready loses nothing.
      if (state == ST_CAPT) begin
        count   <= '0;
        r_bins  <= dut_result;
        r_peak  <= peak_idx;
        r_any   <= peak_any;
        r_valid <= 1'b1;
      end else if (r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef FFT_HOST_OVERRUN_EN
  assign hold = 1'b0;
  always_ff @(posedge clk) begin
    if (!rst_n)                                         overrun <= 1'b0;
    else if ((state == ST_CAPT) && r_valid && !r_ready) overrun <= 1'b1;
  end
`else
  assign hold    = r_valid;
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_host.sv
// tb/tb_fft_frame_host.sv - directed self-checking bench for fft_frame_host
module tb_fft_frame_host;

  typedef logic [7:0] frame_t [8];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        dut_rst_n;
  logic        dut_ena;
  logic [7:0]  dut_data;
  logic [15:0] dut_result;
  logic        r_valid;
  logic        r_ready;
  logic [15:0] r_bins;
  logic [2:0]  r_peak;
  logic        r_any;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0]  core_cnt = '0;
  logic [15:0] result_word = '0;

  fft_frame_host dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .dut_rst_n  (dut_rst_n),
    .dut_ena    (dut_ena),
    .dut_data   (dut_data),
    .dut_result (dut_result),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_bins     (r_bins),
    .r_peak     (r_peak),
    .r_any      (r_any),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Core slot counter model: enable beats reset, result only valid at slot 12.
  always @(posedge clk) begin
    if (dut_ena)         core_cnt <= core_cnt + 4'd1;
    else if (!dut_rst_n) core_cnt <= 4'd0;
  end
  assign dut_result = (core_cnt == 4'd12) ? result_word : 16'hFFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Returns at the falling edge of the cycle whose rising edge takes sample 8.
  task automatic load_frame(input frame_t s, input bit bubbles);
    int idx = 0;
    int iter = 0;
    while (idx < 8 && iter < 200) begin
      @(posedge clk); #1;
      s_valid = bubbles ? ~iter[0] : 1'b1;
      s_data  = s_valid ? s[idx] : 8'h5A;
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      iter++;
    end
    if (idx < 8) check("load_timeout", 32'(idx), 32'd8);
  endtask

  // Walks T+1 .. T+15 after the 8th accept.
  task automatic check_run(input frame_t s, input logic [15:0] res,
                           input logic [2:0] peak, input logic any);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("sync_rst_n", 32'(dut_rst_n), 32'd0);
    check("sync_ena",   32'(dut_ena),   32'd0);
    check("sync_ready", 32'(s_ready),   32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("run_ena_%0d", k),  32'(dut_ena),   32'd1);
      check($sformatf("run_rst_%0d", k),  32'(dut_rst_n), 32'd1);
      check($sformatf("run_data_%0d", k), 32'(dut_data),  (k < 8) ? 32'(s[k]) : 32'd0);
    end
    @(negedge clk);
    check("capt_ena",   32'(dut_ena), 32'd0);
    check("capt_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("res_valid", 32'(r_valid), 32'd1);
    check("res_bins",  32'(r_bins),  32'(res));
    check("res_peak",  32'(r_peak),  32'(peak));
    check("res_any",   32'(r_any),   32'(any));
    check("res_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic run_frame(input frame_t s, input bit bubbles, input logic [15:0] res,
                           input logic [2:0] peak, input logic any);
    result_word = res;
    load_frame(s, bubbles);
    check_run(s, res, peak, any);
  endtask

  task automatic consume();
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    r_ready = 1'b0;
    @(negedge clk);
    check("consumed_valid", 32'(r_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frame_t fa, fb, fc, fd, fe, ff, fg;
    fa = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    fb = '{8'h80, 8'h7F, 8'hFF, 8'h01, 8'hC0, 8'h3F, 8'hFE, 8'h00};
    fc = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    fd = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87};
    fe = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    ff = '{8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F, 8'hA0, 8'hA1};
    fg = '{8'h05, 8'hFB, 8'h0A, 8'hF6, 8'h0F, 8'hF1, 8'h14, 8'hEC};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; r_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready",   32'(s_ready),   32'd0);
    check("rst_dut_rst_n", 32'(dut_rst_n), 32'd0);
    check("rst_dut_ena",   32'(dut_ena),   32'd0);
    check("rst_dut_data",  32'(dut_data),  32'd0);
    check("rst_r_valid",   32'(r_valid),   32'd0);
    check("rst_r_bins",    32'(r_bins),    32'd0);
    check("rst_r_peak",    32'(r_peak),    32'd0);
    check("rst_r_any",     32'(r_any),     32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("fill_s_ready",   32'(s_ready),   32'd1);
    check("fill_dut_rst_n", 32'(dut_rst_n), 32'd1);

    // Frame drive and capture, back-to-back samples.
    run_frame(fa, 1'b0, 16'h0090, 3'd3, 1'b1);
    check("overrun_clear", 32'(overrun), 32'd0);
    consume();

    // Bubbled input, tie between bins 0 and 3.
    run_frame(fb, 1'b1, 16'hA5C3, 3'd0, 1'b1);
    consume();

    // Zero result.
    run_frame(fc, 1'b0, 16'h0000, 3'd0, 1'b0);
    consume();

    // Highest bin only; result left unconsumed for the backpressure case.
    run_frame(fd, 1'b0, 16'h4000, 3'd7, 1'b1);
    result_word = 16'h0C00;
    load_frame(fe, 1'b0);
`ifdef FFT_HOST_OVERRUN_EN
    check_run(fe, 16'h0C00, 3'd5, 1'b1);
    check("overrun_set", 32'(overrun), 32'd1);
`else
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("stall_ena_%0d", k),   32'(dut_ena),   32'd0);
      check($sformatf("stall_rst_%0d", k),   32'(dut_rst_n), 32'd1);
      check($sformatf("stall_ready_%0d", k), 32'(s_ready),   32'd0);
      check($sformatf("stall_bins_%0d", k),  32'(r_bins),    32'h4000);
      check($sformatf("stall_valid_%0d", k), 32'(r_valid),   32'd1);
    end
    consume();
    check_run(fe, 16'h0C00, 3'd5, 1'b1);
    check("overrun_tied", 32'(overrun), 32'd0);
`endif
    consume();

    // Mid-frame reset at RUN slot 5.
    result_word = 16'h0090;
    load_frame(ff, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_reset_slot5", 32'(dut_data), 32'(ff[5]));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mrst_ena",     32'(dut_ena),   32'd0);
    check("mrst_rst_n",   32'(dut_rst_n), 32'd0);
    check("mrst_valid",   32'(r_valid),   32'd0);
    check("mrst_bins",    32'(r_bins),    32'd0);
    check("mrst_data",    32'(dut_data),  32'd0);
    check("mrst_overrun", 32'(overrun),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ready", 32'(s_ready), 32'd1);
    run_frame(fg, 1'b0, 16'h0030, 3'd2, 1'b1);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
